// File: rtl/mac_accum_if.sv
// Streaming bundle for mac_accum: activation/weight/bias beats in, one dot-product sum out.
// The master side drives the beats and out_ready; the slave side is the accumulator.
interface mac_accum_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = 32
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_act;
  logic [WEIGHT_WIDTH-1:0] in_weight;
  logic [SUM_WIDTH-1:0]    in_bias;
  logic                    out_valid;
  logic                    out_ready;
  logic [SUM_WIDTH-1:0]    out_sum;

  modport master (
    output in_valid, in_act, in_weight, in_bias, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_act, in_weight, in_bias, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/mac_accum.sv
// Dot-product accumulator: registered multiply, bias-seeded accumulate, one held sum per vector.
// Optional macro MAC_ACCUM_SAT_EN makes every accumulate step saturate instead of wrapping.
module mac_accum #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = 32,
  parameter int NUM_IN       = 16
) (
  input  logic        clk,
  input  logic        rst,
  mac_accum_if.slave  bus
);
  localparam int PROD_W = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int CNT_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_IN - 1);

  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [PROD_W-1:0]     prod_reg;
  logic                  p_valid_reg;
  logic                  p_first_reg;
  logic [SUM_WIDTH-1:0]  bias_reg;
  logic [SUM_WIDTH-1:0]  acc_reg;
  logic [SUM_WIDTH-1:0]  acc_next;
  logic                  out_valid_reg;
  logic [SUM_WIDTH-1:0]  out_sum_reg;

  logic                  in_ready_int;
  logic                  accept;
  logic                  last_beat;
  logic                  handshake;
  logic [PROD_W-1:0]     act_ext;
  logic [PROD_W-1:0]     weight_ext;
  logic [PROD_W-1:0]     prod_next;
  logic [SUM_WIDTH-1:0]  prod_ext;
  logic [SUM_WIDTH-1:0]  addend;

  assign accept    = bus.in_valid && in_ready_int;
  assign last_beat = (cnt_reg == CNT_LAST);
  assign handshake = out_valid_reg && bus.out_ready;

  // Operands are widened to the product width so the truncated product is the exact signed result.
  assign act_ext    = {{WEIGHT_WIDTH{bus.in_act[DATA_WIDTH-1]}}, bus.in_act};
  assign weight_ext = {{DATA_WIDTH{bus.in_weight[WEIGHT_WIDTH-1]}}, bus.in_weight};
  assign prod_next  = act_ext * weight_ext;

  generate
    if (SUM_WIDTH > PROD_W) begin : g_sext
      assign prod_ext = {{(SUM_WIDTH-PROD_W){prod_reg[PROD_W-1]}}, prod_reg};
    end else begin : g_nosext
      assign prod_ext = prod_reg;
    end
  endgenerate

  assign addend = p_first_reg ? bias_reg : acc_reg;

`ifdef MAC_ACCUM_SAT_EN
  logic [SUM_WIDTH:0] sum_wide;
  always_comb begin
    sum_wide = {addend[SUM_WIDTH-1], addend} + {prod_ext[SUM_WIDTH-1], prod_ext};
    acc_next = sum_wide[SUM_WIDTH-1:0];
    // Top two bits disagree only on overflow; the extra bit carries the true sign.
    if (sum_wide[SUM_WIDTH] != sum_wide[SUM_WIDTH-1]) begin
      acc_next = sum_wide[SUM_WIDTH] ? {1'b1, {(SUM_WIDTH-1){1'b0}}}
                                     : {1'b0, {(SUM_WIDTH-1){1'b1}}};
    end
  end
`else
  always_comb begin
    acc_next = addend + prod_ext;
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ACC;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ACC:     if (accept && last_beat) state_next = DRAIN;
      DRAIN:   state_next = OUT;
      OUT:     if (handshake) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready_int = 1'b0;
    case (state_reg)
      ACC:     in_ready_int = !rst;
      default: in_ready_int = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      prod_reg      <= '0;
      p_valid_reg   <= 1'b0;
      p_first_reg   <= 1'b0;
      bias_reg      <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
    end else begin
      p_valid_reg <= accept;
      if (accept) begin
        cnt_reg     <= last_beat ? '0 : cnt_reg + CNT_W'(1);
        prod_reg    <= prod_next;
        p_first_reg <= (cnt_reg == '0);
        if (cnt_reg == '0) bias_reg <= bus.in_bias;
      end

      if (p_valid_reg)    acc_reg <= acc_next;
      else if (handshake) acc_reg <= '0;

      // The sum is captured one cycle into OUT, after the last product has landed.
      if (state_reg == OUT && !out_valid_reg) begin
        out_valid_reg <= 1'b1;
        out_sum_reg   <= acc_reg;
      end else if (handshake) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: a 32-bit and a 16-bit instance share one beat stream and are
// checked against an arithmetic dot-product model, with latency and handshake checks.
module tb_mac_accum;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_accum_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SUM_WIDTH(32)) bus32 ();
  mac_accum_if #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SUM_WIDTH(16)) bus16 ();

  mac_accum #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SUM_WIDTH(32), .NUM_IN(N)) dut32 (
    .clk(clk), .rst(rst), .bus(bus32)
  );
  mac_accum #(.DATA_WIDTH(8), .WEIGHT_WIDTH(8), .SUM_WIDTH(16), .NUM_IN(N)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16)
  );

  assign bus16.in_valid  = bus32.in_valid;
  assign bus16.in_act    = bus32.in_act;
  assign bus16.in_weight = bus32.in_weight;
  assign bus16.in_bias   = bus32.in_bias[15:0];
  assign bus16.out_ready = bus32.out_ready;

  int tests = 0;
  int fails = 0;
  int cur_act[N];
  int cur_wt[N];

  function automatic longint fit(longint v, int w);
    longint m;
    m = longint'(1) << w;
    v = v & (m - 1);
    if (v >= (m >>> 1)) v = v - m;
    return v;
  endfunction

  // Reference: bias plus sum of products, reduced to w bits after every step.
  function automatic longint model(longint bias, int w);
    longint acc, hi, lo;
    hi  = (longint'(1) << (w - 1)) - 1;
    lo  = -hi - 1;
    acc = fit(bias, w);
    for (int i = 0; i < N; i++) begin
      acc = acc + longint'(cur_act[i]) * longint'(cur_wt[i]);
`ifdef MAC_ACCUM_SAT_EN
      if (acc > hi) acc = hi;
      else if (acc < lo) acc = lo;
`else
      acc = fit(acc, w);
`endif
    end
    return acc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_beat(int i, logic [31:0] bias);
    int w;
    bus32.in_valid  = 1'b1;
    bus32.in_act    = 8'(cur_act[i]);
    bus32.in_weight = 8'(cur_wt[i]);
    bus32.in_bias   = (i == 0) ? bias : $urandom;
    w = 0;
    while (!bus32.in_ready && w < 20) begin
      tick();
      w++;
    end
    check("ready_wait", {31'd0, bus32.in_ready}, 32'd1);
    tick();
    bus32.in_valid = 1'b0;
  endtask

  task automatic run_vec(string name, logic [31:0] bias, int gap, int hold);
    logic [31:0] e32, e16, held;
    e32 = 32'(model(longint'($signed(bias)), 32));
    e16 = {16'h0, 16'(model(longint'($signed(bias)), 16))};
    bus32.out_ready = (hold == 0);
    for (int i = 0; i < N; i++) begin
      send_beat(i, bias);
      if (i < N - 1) for (int g = 0; g < gap; g++) tick();
    end
    // Cycle after the last accept: DRAIN
    if (hold > 0) begin
      bus32.in_valid  = 1'b1;
      bus32.in_act    = 8'($urandom);
      bus32.in_weight = 8'($urandom);
    end
    check({name, "_drain_ready"}, {31'd0, bus32.in_ready}, 32'd0);
    check({name, "_drain_valid"}, {31'd0, bus32.out_valid}, 32'd0);
    tick();
    check({name, "_t1_valid"}, {31'd0, bus32.out_valid}, 32'd0);
    tick();
    check({name, "_t2_valid"}, {31'd0, bus32.out_valid}, 32'd1);
    check({name, "_sum32"}, bus32.out_sum, e32);
    check({name, "_valid16"}, {31'd0, bus16.out_valid}, 32'd1);
    check({name, "_sum16"}, {16'h0, bus16.out_sum}, e16);
    held = bus32.out_sum;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, "_bp_valid"}, {31'd0, bus32.out_valid}, 32'd1);
      check({name, "_bp_sum"}, bus32.out_sum, held);
      check({name, "_bp_ready"}, {31'd0, bus32.in_ready}, 32'd0);
    end
    bus32.out_ready = 1'b1;
    tick();
    bus32.in_valid = 1'b0;
    check({name, "_hs_valid"}, {31'd0, bus32.out_valid}, 32'd0);
    check({name, "_hs_ready"}, {31'd0, bus32.in_ready}, 32'd1);
    $display("[TB] vec %s bias=%h got32=%h exp32=%h got16=%h exp16=%h",
             name, bias, bus32.out_sum, e32, bus16.out_sum, e16[15:0]);
  endtask

  task automatic set_vec(int a0, int a1, int a2, int a3, int w0, int w1, int w2, int w3);
    cur_act[0] = a0; cur_act[1] = a1; cur_act[2] = a2; cur_act[3] = a3;
    cur_wt[0]  = w0; cur_wt[1]  = w1; cur_wt[2]  = w2; cur_wt[3]  = w3;
  endtask

  initial begin
    rst             = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.in_act    = '0;
    bus32.in_weight = '0;
    bus32.in_bias   = '0;
    bus32.out_ready = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, bus32.out_valid}, 32'd0);
    check("rst_sum", bus32.out_sum, 32'd0);
    check("rst_ready", {31'd0, bus32.in_ready}, 32'd0);
    check("rst_sum16", {16'h0, bus16.out_sum}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, bus32.in_ready}, 32'd1);

    set_vec(1, 2, 3, 4, 1, 1, 1, 1);
    run_vec("basic", 32'h0, 0, 0);
    check("basic_gold", bus32.out_sum, 32'h0000000A);

    set_vec(-128, -128, -128, -128, 127, 127, 127, 127);
    run_vec("extreme", 32'h0, 0, 0);
    check("extreme_gold", bus32.out_sum, 32'hFFFF0200);

    set_vec(0, 0, 0, 0, 9, -7, 5, 3);
    run_vec("bias_gap", 32'h00000064, 1, 0);
    check("bias_gap_gold", bus32.out_sum, 32'h00000064);

    set_vec(2, 2, 2, 2, 3, 3, 3, 3);
    run_vec("clear", 32'h0, 0, 0);
    check("clear_gold", bus32.out_sum, 32'h00000018);

    set_vec(-5, 17, 100, -90, 33, -2, 7, 11);
    run_vec("backpr", 32'hFFFFFF00, 0, 5);

    // Reset with half a vector in flight
    set_vec(50, 60, 70, 80, 9, 9, 9, 9);
    send_beat(0, 32'h12345678);
    send_beat(1, 32'h0);
    rst = 1'b1;
    tick();
    check("midrst_valid", {31'd0, bus32.out_valid}, 32'd0);
    check("midrst_sum", bus32.out_sum, 32'd0);
    check("midrst_ready", {31'd0, bus32.in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_ready_after", {31'd0, bus32.in_ready}, 32'd1);
    set_vec(1, 1, 1, 1, 5, 5, 5, 5);
    run_vec("after_rst", 32'h0, 0, 0);
    check("after_rst_gold", bus32.out_sum, 32'h00000014);

    set_vec(127, 127, 127, 127, 127, 127, 127, 127);
    run_vec("ovf", 32'h0, 0, 0);
`ifdef MAC_ACCUM_SAT_EN
    check("ovf16_gold", {16'h0, bus16.out_sum}, 32'h00007FFF);
`else
    check("ovf16_gold", {16'h0, bus16.out_sum}, 32'h0000FC04);
`endif

    for (int v = 0; v < 20; v++) begin
      logic [31:0] b;
      for (int i = 0; i < N; i++) begin
        cur_act[i] = int'($urandom_range(0, 255)) - 128;
        cur_wt[i]  = int'($urandom_range(0, 255)) - 128;
      end
      b = (v % 3 == 0) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
      run_vec("rand", b, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
